// File: rtl/icache_pkg.sv
// Shared types and size derivations for the instruction-cache line fill block.
package icache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_GAP   = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } fill_state_t;

  function automatic int calc_line_w(input int block_size, input int num_blocks);
    return 8 * block_size * num_blocks;
  endfunction

  function automatic int calc_beats(input int block_size, input int num_blocks);
    return calc_line_w(block_size, num_blocks) / WORD_W;
  endfunction

endpackage

// File: rtl/icache_line_fill_buf.sv
// One-entry buffer holding the address and data of the last fully served line.
module icache_line_fill_buf #(
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [31:0]       lookup_addr,
  output logic              hit,
  output logic [LINE_W-1:0] rd_data
);

  logic [31:0]       buf_addr;
  logic [LINE_W-1:0] buf_data;
  logic              buf_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (wr_en) begin
      buf_addr  <= wr_addr;
      buf_data  <= wr_data;
      buf_valid <= 1'b1;
    end
  end

  assign hit     = buf_valid && (buf_addr == lookup_addr);
  assign rd_data = buf_data;

endmodule

// File: rtl/icache_line_fill.sv
// Assembles one cache line from BEATS sequential 32-bit backing reads.
// Define ICACHE_LINE_FILL_BUFFER_EN to add a last-line buffer that short-cuts repeat requests.
module icache_line_fill import icache_pkg::*; #(
  parameter  int BLOCK_SIZE = 2,
  parameter  int NUM_BLOCKS = 4,
  localparam int LINE_W     = calc_line_w(BLOCK_SIZE, NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic [LINE_W-1:0] req_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [31:0]       mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int BEATS = calc_beats(BLOCK_SIZE, NUM_BLOCKS);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  fill_state_t       state, state_nxt;
  logic [BW-1:0]     beat;
  logic [31:0]       base;
  logic              aborted;
  logic [31:0]       acc_addr;
  logic              hit;
  logic [LINE_W-1:0] buf_data;

  assign acc_addr = req_addr & 32'hFFFF_FFFC;

`ifdef ICACHE_LINE_FILL_BUFFER_EN
  icache_line_fill_buf #(.LINE_W(LINE_W)) u_buf (
    .clk         (clk),
    .resetn      (resetn),
    .wr_en       (state == ST_RESP),
    .wr_addr     (base),
    .wr_data     (req_rdata),
    .lookup_addr (acc_addr),
    .hit         (hit),
    .rd_data     (buf_data)
  );
`else
  assign hit      = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // A dropped request is remembered so the in-flight beat finishes but nothing further issues.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = hit ? ST_RESP : ST_FETCH;
      ST_FETCH: if (mem_ready) begin
                  if (aborted || !req_valid) state_nxt = ST_IDLE;
                  else if (beat == LAST_BEAT) state_nxt = ST_RESP;
                  else                        state_nxt = ST_GAP;
                end
      ST_GAP:   state_nxt = (aborted || !req_valid) ? ST_IDLE : ST_FETCH;
      ST_RESP:  state_nxt = ST_DRAIN;
      ST_DRAIN: if (!req_valid) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat      <= '0;
      base      <= '0;
      aborted   <= 1'b0;
      req_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          base    <= acc_addr;
          beat    <= '0;
          aborted <= 1'b0;
          if (hit) req_rdata <= buf_data;
        end
        ST_FETCH: begin
          if (!req_valid) aborted <= 1'b1;
          if (mem_ready) req_rdata[WORD_W*beat +: WORD_W] <= mem_rdata;
        end
        ST_GAP: begin
          beat <= beat + BW'(1);
          if (!req_valid) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Gating with req_valid keeps a misbehaving requester from ever seeing an unsolicited pulse.
  assign req_ready = (state == ST_RESP) && req_valid;
  assign mem_valid = (state == ST_FETCH);
  assign mem_addr  = base + {{(30-BW){1'b0}}, beat, 2'b00};

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: vector table, corner sequences, random traffic vs. a line model.
module tb_icache_line_fill;

  localparam int LINE_W = 64;
  localparam int BEATS  = 2;
`ifdef ICACHE_LINE_FILL_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn, req_valid, req_ready, mem_valid, mem_ready;
  logic [31:0]       req_addr, mem_addr, mem_rdata;
  logic [LINE_W-1:0] req_rdata;

  int          checks = 0, errors = 0;
  int          mem_delay = 0;
  logic [31:0] acc_q[$];
  bit          bvalid = 1'b0;
  logic [31:0] bbase = '0;
  logic [31:0] last_served = 32'h1000;

  logic        pmv = 1'b0, pmr = 1'b0, prst = 1'b0;
  logic [31:0] pma = '0;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    int          hold;
    int          lat;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [63:0] line;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000) return 32'h1111_1111;
    if (a == 32'h1004) return 32'h2222_2222;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [LINE_W-1:0] model_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < BEATS; i++) l[32*i +: 32] = mem_word(base + 32'(4*i));
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Backing memory: mem_ready rises mem_delay cycles after mem_valid, data is a function of address.
  initial begin
    int cnt;
    cnt = 0; mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid !== 1'b1) begin
        mem_ready = 1'b0; cnt = 0;
      end else begin
        if (mem_ready) cnt = 0;
        if (cnt >= mem_delay) begin
          mem_ready = 1'b1; mem_rdata = mem_word(mem_addr);
        end else begin
          mem_ready = 1'b0; cnt++;
        end
      end
    end
  end

  // Protocol monitor and handshake log.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1 && mem_ready === 1'b1) acc_q.push_back(mem_addr);
      if (req_ready === 1'b1) chk("ready_needs_valid", 64'(req_valid), 64'd1);
      if (pmv === 1'b1 && prst === 1'b1 && pmr === 1'b0) begin
        chk("mem_valid_held", 64'(mem_valid), 64'd1);
        if (mem_valid === 1'b1) chk("mem_addr_stable", 64'(mem_addr), 64'(pma));
      end
      pmv = mem_valid; pmr = mem_ready; pma = mem_addr; prst = resetn;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [31:0] addr, input int delay, input int hold,
                        output int lat, output logic [LINE_W-1:0] line);
    mem_delay = delay;
    @(posedge clk); #1;
    acc_q.delete();
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_addr = $urandom;
    lat = -1; line = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin lat = k; line = req_rdata; break; end
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      if (h == hold) req_valid = 1'b0;
      @(negedge clk);
      chk("drain_quiet", {62'd0, req_ready, mem_valid}, 64'd0);
    end
    chk("rdata_stable", req_rdata, line);
  endtask

  task automatic serve_model(input logic [31:0] addr, input int delay, input int hold);
    logic [31:0]       base;
    bit                hit;
    int                lat;
    logic [LINE_W-1:0] line;
    base = addr & 32'hFFFF_FFFC;
    hit  = BUF_EN && bvalid && (bbase == base);
    do_req(addr, delay, hold, lat, line);
    chk("model_lat", 64'(lat), hit ? 64'd1 : 64'(BEATS*(delay+1) + BEATS));
    chk("model_line", line, model_line(base));
    chk("model_reads", 64'(acc_q.size()), hit ? 64'd0 : 64'(BEATS));
    if (!hit && acc_q.size() == BEATS)
      for (int i = 0; i < BEATS; i++) chk("model_addr", 64'(acc_q[i]), 64'(base + 32'(4*i)));
    if (lat >= 0) begin bvalid = 1'b1; bbase = base; last_served = addr; end
  endtask

  task automatic do_abort(input logic [31:0] addr, input int delay, input int drop);
    bit seen;
    mem_delay = delay;
    @(posedge clk); #1;
    acc_q.delete();
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_addr = $urandom;
    for (int j = 0; j < drop; j++) begin @(posedge clk); #1; end
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (delay + 8) begin
      @(negedge clk);
      if (req_ready === 1'b1) seen = 1'b1;
    end
    chk("abort_no_ready", 64'(seen), 64'd0);
    chk("abort_reads", 64'(acc_q.size()), 64'd1);
    chk("abort_idle", 64'(mem_valid), 64'd0);
    if (acc_q.size() >= 1) chk("abort_addr", 64'(acc_q[0]), 64'(addr & 32'hFFFF_FFFC));
  endtask

  initial begin
    int                lat;
    logic [LINE_W-1:0] line;
    int                r, d;
    logic [31:0]       a;

    tbl[0] = '{32'h0000_1000, 0, 0,  4, 32'h0000_1000, 32'h0000_1004, 64'h2222_2222_1111_1111};
    tbl[1] = '{32'h0000_2000, 3, 0, 10, 32'h0000_2000, 32'h0000_2004, 64'h2004_DFFB_2000_DFFF};
    tbl[2] = '{32'h0000_3000, 1, 5,  6, 32'h0000_3000, 32'h0000_3004, 64'h3004_CFFB_3000_CFFF};
    tbl[3] = '{32'hFFFF_FFFC, 0, 1,  4, 32'hFFFF_FFFC, 32'h0000_0000, 64'h0000_FFFF_FFFC_0003};
    tbl[4] = '{32'h0000_1233, 2, 0,  8, 32'h0000_1230, 32'h0000_1234, 64'h1234_EDCB_1230_EDCF};

    resetn = 1'b0; req_valid = 1'b0; req_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_req_rdata", req_rdata, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_req(tbl[i].addr, tbl[i].delay, tbl[i].hold, lat, line);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d_line", i), line, tbl[i].line);
      chk($sformatf("vec%0d_reads", i), 64'(acc_q.size()), 64'd2);
      if (acc_q.size() == 2) begin
        chk($sformatf("vec%0d_a0", i), 64'(acc_q[0]), 64'(tbl[i].a0));
        chk($sformatf("vec%0d_a1", i), 64'(acc_q[1]), 64'(tbl[i].a1));
      end
      if (lat >= 0) begin bvalid = 1'b1; bbase = tbl[i].addr & 32'hFFFF_FFFC; end
    end

    // Abort during the first beat wait; the aborted line must not become a buffer entry.
    do_abort(32'h0000_4000, 3, 1);
    serve_model(32'h0000_1230, 0, 0);
    serve_model(32'h0000_4000, 0, 0);

    // Repeat request: buffered builds answer from the buffer, otherwise a full fill.
    serve_model(32'h0000_1000, 0, 0);
    serve_model(32'h0000_1000, 0, 0);
    serve_model(32'h0000_1008, 0, 0);

    // Reset in the middle of a fill.
    mem_delay = 3;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0000_5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_mem_valid", 64'(mem_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_req_rdata", req_rdata, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    bvalid = 1'b0;
    serve_model(32'h0000_1000, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 3) ? last_served : $urandom;
      if (r == 9) begin
        d = $urandom_range(1, 3);
        do_abort(a, d, $urandom_range(0, d));
      end else begin
        d = $urandom_range(0, 3);
        serve_model(a, d, $urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
